// File: rtl/dds_sweep_ctrl_if.sv
// dds_sweep_ctrl_if
// Groups the sweep configuration handshake, the abort request and the DDS
// phase/status outputs of dds_sweep_ctrl.
//   master : host/register side (drives cfg_*, abort; observes status)
//   slave  : dds_sweep_ctrl
// Signals:
//   cfg_valid/cfg_ready  configuration handshake (ready only while idle)
//   cfg_start_inc        first phase increment
//   cfg_stop_inc         final phase increment
//   cfg_step             increment change per segment
//   cfg_dwell            each increment is held for cfg_dwell+1 cycles
//   cfg_continuous       1 = repeat sweep forever, 0 = single sweep
//   abort                stop the running sweep
//   angle                phase to dds_top
//   cur_inc              increment currently applied
//   busy                 sweep running
//   done                 one-cycle pulse at the end of a single sweep
interface dds_sweep_ctrl_if #(
  parameter int DDS_P_DW = 24,
  parameter int DWELL_W  = 16
);
  logic                cfg_valid;
  logic                cfg_ready;
  logic [DDS_P_DW-1:0] cfg_start_inc;
  logic [DDS_P_DW-1:0] cfg_stop_inc;
  logic [DDS_P_DW-1:0] cfg_step;
  logic [DWELL_W-1:0]  cfg_dwell;
  logic                cfg_continuous;
  logic                abort;
  logic [DDS_P_DW-1:0] angle;
  logic [DDS_P_DW-1:0] cur_inc;
  logic                busy;
  logic                done;

  modport master (
    output cfg_valid, cfg_start_inc, cfg_stop_inc, cfg_step, cfg_dwell,
           cfg_continuous, abort,
    input  cfg_ready, angle, cur_inc, busy, done
  );

  modport slave (
    input  cfg_valid, cfg_start_inc, cfg_stop_inc, cfg_step, cfg_dwell,
           cfg_continuous, abort,
    output cfg_ready, angle, cur_inc, busy, done
  );
endinterface

// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl
// Frequency-sweep scheduler driving the phase (angle) input of dds_top.
// A configuration handshake loads start/stop increment, step and dwell; the
// block then accumulates phase with an increment that steps from start to
// stop, holding each value for dwell+1 cycles.
// Ports:
//   clk    the only clock
//   rst_n  asynchronous active-low reset
//   sw     dds_sweep_ctrl_if.slave (configuration, abort, angle/status)
// Build option:
//   DDS_SWEEP_TRIANGLE_EN  when defined, the sweep returns from stop back to
//                          start (triangle); otherwise sawtooth only.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | waiting for a configuration, angle held
// S_RUN  | accumulating, increment stepping up towards stop
// S_DOWN | accumulating, increment stepping down towards start (triangle)
module dds_sweep_ctrl #(
  parameter int DDS_P_DW = 24,
  parameter int DWELL_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  dds_sweep_ctrl_if.slave  sw
);

`ifdef DDS_SWEEP_TRIANGLE_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DOWN} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_RUN} state_t;
`endif

  state_t              state_q, state_d;
  logic [DDS_P_DW-1:0] angle_q, angle_d;
  logic [DDS_P_DW-1:0] cur_inc_q, cur_inc_d;
  logic [DWELL_W-1:0]  dwell_cnt_q, dwell_cnt_d;
  logic [DWELL_W-1:0]  dwell_q, dwell_d;
  logic [DDS_P_DW-1:0] start_q, start_d;
  logic [DDS_P_DW-1:0] stop_q, stop_d;
  logic [DDS_P_DW-1:0] step_q, step_d;
  logic                cont_q, cont_d;
  logic                done_q, done_d;

  // Up-step is formed one bit wider so a large step can never wrap past stop.
  logic [DDS_P_DW:0]   sum_up;
  logic [DDS_P_DW-1:0] up_next;
  logic [DDS_P_DW-1:0] restart_inc;
  logic                seg_end;

  assign sum_up  = {1'b0, cur_inc_q} + {1'b0, step_q};
  assign up_next = (sum_up > {1'b0, stop_q}) ? stop_q : sum_up[DDS_P_DW-1:0];
  assign seg_end = (dwell_cnt_q == '0);

`ifdef DDS_SWEEP_TRIANGLE_EN
  // Down-step: borrow in the wide difference means we went below zero,
  // which clamps to start just like undershooting start does.
  logic [DDS_P_DW:0]   diff_dn;
  logic [DDS_P_DW-1:0] dn_next;
  logic [DDS_P_DW:0]   sum_rs;

  assign diff_dn = {1'b0, cur_inc_q} - {1'b0, step_q};
  assign dn_next = (diff_dn[DDS_P_DW] || (diff_dn[DDS_P_DW-1:0] < start_q))
                   ? start_q : diff_dn[DDS_P_DW-1:0];
  // Continuous triangle skips the start segment on re-entry, since the
  // descent just finished on it.
  assign sum_rs      = {1'b0, start_q} + {1'b0, step_q};
  assign restart_inc = (sum_rs > {1'b0, stop_q}) ? stop_q : sum_rs[DDS_P_DW-1:0];
`else
  assign restart_inc = start_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      angle_q     <= '0;
      cur_inc_q   <= '0;
      dwell_cnt_q <= '0;
      dwell_q     <= '0;
      start_q     <= '0;
      stop_q      <= '0;
      step_q      <= '0;
      cont_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      angle_q     <= angle_d;
      cur_inc_q   <= cur_inc_d;
      dwell_cnt_q <= dwell_cnt_d;
      dwell_q     <= dwell_d;
      start_q     <= start_d;
      stop_q      <= stop_d;
      step_q      <= step_d;
      cont_q      <= cont_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    logic sweep_end;
    state_d     = state_q;
    angle_d     = angle_q;
    cur_inc_d   = cur_inc_q;
    dwell_cnt_d = dwell_cnt_q;
    dwell_d     = dwell_q;
    start_d     = start_q;
    stop_d      = stop_q;
    step_d      = step_q;
    cont_d      = cont_q;
    done_d      = 1'b0;
    sweep_end   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (sw.cfg_valid) begin
          state_d     = S_RUN;
          cur_inc_d   = sw.cfg_start_inc;
          dwell_cnt_d = sw.cfg_dwell;
          dwell_d     = sw.cfg_dwell;
          start_d     = sw.cfg_start_inc;
          stop_d      = sw.cfg_stop_inc;
          step_d      = sw.cfg_step;
          cont_d      = sw.cfg_continuous;
        end
      end

      S_RUN: begin
        angle_d = angle_q + cur_inc_q;
        if (sw.abort) begin
          state_d = S_IDLE;
        end else if (!seg_end) begin
          dwell_cnt_d = dwell_cnt_q - 1'b1;
        end else if (cur_inc_q >= stop_q) begin
`ifdef DDS_SWEEP_TRIANGLE_EN
          // start >= stop has no descent: it is a single segment.
          if (cur_inc_q > start_q) begin
            state_d     = S_DOWN;
            cur_inc_d   = dn_next;
            dwell_cnt_d = dwell_q;
          end else begin
            sweep_end = 1'b1;
          end
`else
          sweep_end = 1'b1;
`endif
        end else begin
          cur_inc_d   = up_next;
          dwell_cnt_d = dwell_q;
        end
      end

`ifdef DDS_SWEEP_TRIANGLE_EN
      S_DOWN: begin
        angle_d = angle_q + cur_inc_q;
        if (sw.abort) begin
          state_d = S_IDLE;
        end else if (!seg_end) begin
          dwell_cnt_d = dwell_cnt_q - 1'b1;
        end else if (cur_inc_q <= start_q) begin
          sweep_end = 1'b1;
        end else begin
          cur_inc_d   = dn_next;
          dwell_cnt_d = dwell_q;
        end
      end
`endif

      default: state_d = S_IDLE;
    endcase

    if (sweep_end) begin
      if (cont_q) begin
        state_d     = S_RUN;
        cur_inc_d   = restart_inc;
        dwell_cnt_d = dwell_q;
      end else begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
    end
  end

  assign sw.angle     = angle_q;
  assign sw.cur_inc   = cur_inc_q;
  assign sw.busy      = (state_q != S_IDLE);
  assign sw.cfg_ready = (state_q == S_IDLE);
  assign sw.done      = done_q;

endmodule

// File: doc/dds_sweep_ctrl.md
# dds_sweep_ctrl

Frequency-sweep scheduler that drives the 24-bit `angle` input of `dds_top`. A configuration handshake loads a sweep: start increment, stop increment, step and dwell. The block then runs a phase accumulator whose increment steps from start to stop, holding each value for a programmable number of cycles. It sits between the host/register layer and `dds_top`, and it is the only writer of the DDS phase.

## Interface
Parameters:
- `DDS_P_DW`, 24: phase, angle and increment width.
- `DWELL_W`, 16: dwell counter width.

Ports:
- `clk`, in, 1: the only clock.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `cfg_valid`, in, 1: sweep configuration valid.
- `cfg_ready`, out, 1: block can accept a configuration (high only in IDLE).
- `cfg_start_inc`, in, DDS_P_DW: first phase increment.
- `cfg_stop_inc`, in, DDS_P_DW: final phase increment.
- `cfg_step`, in, DDS_P_DW: amount added to the increment per segment.
- `cfg_dwell`, in, DWELL_W: each increment is held for cfg_dwell+1 cycles.
- `cfg_continuous`, in, 1: 1 = restart the sweep forever; 0 = single sweep.
- `abort`, in, 1: stop the sweep immediately.
- `angle`, out, DDS_P_DW: phase to `dds_top`, registered.
- `cur_inc`, out, DDS_P_DW: increment currently applied, registered.
- `busy`, out, 1: high in RUN.
- `done`, out, 1: one-cycle pulse when a single sweep completes.

## Operation
- States: IDLE, RUN; DOWN exists only with the macro (see Configuration).
- Reset values: state=IDLE, `angle`=0, `cur_inc`=0, dwell_cnt=0, `busy`=0, `done`=0, `cfg_ready`=1.
- IDLE:
  - `angle` holds its value; no accumulation.
  - Acceptance occurs on the edge where cfg_valid&&cfg_ready. On that edge: state→RUN, `cur_inc`←cfg_start_inc, dwell_cnt←cfg_dwell, and cfg_stop_inc, cfg_step and cfg_continuous are latched.
- RUN, every edge:
  - `angle` ← `angle`+`cur_inc`, modulo 2^DDS_P_DW, wrapping silently.
  - If dwell_cnt≠0: dwell_cnt decrements.
  - If dwell_cnt=0, the segment ends:
    - If `cur_inc` ≥ stop (unsigned), the sweep ends.
    - Otherwise `cur_inc` ← min(`cur_inc`+step, stop). The sum is computed at DDS_P_DW+1 bits, so it never wraps. dwell_cnt reloads the latched dwell.
  - Sweep end with continuous=1: `cur_inc`←start and dwell_cnt reloads. There is no gap and the phase stays continuous.
  - Sweep end with continuous=0: state→IDLE, `done` pulses for 1 cycle, `cur_inc` holds.
- start ≥ stop: the sweep is a single segment at the start increment.
- step=0 with start<stop: the increment never changes and RUN lasts until `abort`. This is legal.
- `abort` in RUN:
  - Takes priority over a segment end or sweep end on the same edge.
  - state→IDLE, no `done` pulse, `angle` holds at its post-edge value.
  - `abort` in IDLE is ignored.
- `cfg_valid` during RUN is ignored (`cfg_ready`=0). Configuration inputs are sampled only at acceptance.
- A new sweep does not clear `angle`, so the phase is continuous across sweeps.

## Timing
- Acceptance on edge k:
  - `busy`=1 and `cfg_ready`=0 from cycle k+1.
  - The first accumulation happens on edge k+1, so angle(k+1) = angle(k)+start.
- Each increment value contributes exactly cfg_dwell+1 accumulations.
- Single sweep of N segments: the final accumulation is on edge k+N·(dwell+1). On that same edge `busy` drops and `done` and `cfg_ready` rise.
- Back-to-back operation: a configuration presented in the `done` cycle is accepted on the next edge.
- `rst_n` low at any time, including mid-sweep, immediately forces all reset values. There is no `done` pulse.

## Configuration
- `DDS_SWEEP_TRIANGLE_EN` defined:
  - Reaching stop at a segment end goes to state DOWN instead of ending the sweep.
  - In DOWN, each segment end sets `cur_inc` ← max(`cur_inc`−step, start).
  - The sweep ends at the segment end where `cur_inc` ≤ start.
  - Continuous mode re-enters RUN with `cur_inc`←start+step, clamped to stop. The start dwell is not repeated.
- `DDS_SWEEP_TRIANGLE_EN` undefined: sawtooth sweep only; DOWN and its logic are absent.

## Test plan
- Fixed tone: start=stop=0x080000, dwell=3, angle=0 → `angle` reads 0x080000, 0x100000, 0x180000, 0x200000. `done` fires on the 4th accumulation edge, followed by IDLE.
- Ramp: start=0x010000, step=0x010000, stop=0x030000, dwell=1 → `cur_inc` sequence is 1,1,2,2,3,3 (×0x10000), `done` after 6 accumulations, final `angle`=0x0C0000.
- Clamp and wrap:
  - start=0x010000, step=0x018000, stop=0x020000, dwell=0 → `cur_inc` is 0x010000 then 0x020000, then `done`.
  - Preload angle 0xFF0000 with inc 0x020000 → next `angle` is 0x010000.
- Abort: assert `abort` together with the edge that would end a segment → IDLE, no `done`, `angle` frozen, `cfg_ready`=1 next cycle.
- Continuous and reset: continuous=1 with the ramp above → `cur_inc` returns to 0x010000 after the 6th accumulation with no idle cycle. Pulling `rst_n` low mid-sweep → `angle`=0, `busy`=0, `done`=0 immediately.
- Triangle (macro defined): the ramp above gives `cur_inc` sequence 1,1,2,2,3,3,2,2,1,1 (×0x10000), then `done`.
